// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that shares one external combinational
// ALU between two requesters and returns each result over a valid/ready
// response channel.
//
// Optional feature macro: ALU_ARB_FLAGS_EN
//   defined   -> resp_z/resp_n/resp_v are computed and registered with the result
//   undefined -> resp_z/resp_n/resp_v are tied to 0 and the flag logic is absent
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid / reqN_ready     request handshake per requester (N = 0,1)
//   reqN_a, reqN_b, reqN_op     request operands and opcode
//   alu_a, alu_b, alu_op        operands and opcode driven to the shared ALU
//   alu_result                  combinational result returned by the ALU
//   resp_valid / resp_ready     response handshake
//   resp_id, resp_result        requester index and registered ALU result
//   resp_z, resp_n, resp_v      zero / negative / signed-overflow flags
module alu_share_arb #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_z,
  output logic              resp_n,
  output logic              resp_v
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            r_state;
  logic              r_last;      // index of the requester granted most recently
  logic [DATA_W-1:0] r_a, r_b;
  logic [OP_W-1:0]   r_op;
  logic              r_id;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic [DATA_W-1:0] r_result;

  logic w_gnt0, w_gnt1;

  // On a tie the requester that was not granted last wins.
  assign w_gnt0 = (r_state == IDLE) && !rst && req0_valid && (!req1_valid ||  r_last);
  assign w_gnt1 = (r_state == IDLE) && !rst && req1_valid && (!req0_valid || !r_last);

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_op      = r_op;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_result     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_a     <= w_gnt1 ? req1_a  : req0_a;
            r_b     <= w_gnt1 ? req1_b  : req0_b;
            r_op    <= w_gnt1 ? req1_op : req0_op;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result     <= alu_result;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);

  logic              w_arith;
  logic [DATA_W:0]   w_sum;
  logic              w_z, w_n, w_v;
  logic              r_z, r_n, r_v;

  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

  // Overflow comes from a private sign-extended adder on the latched operands,
  // so a saturating ALU still reports the true overflow.
  always_comb begin
    w_sum = '0;
    if (r_op == OP_SUB) w_sum = {r_a[DATA_W-1], r_a} - {r_b[DATA_W-1], r_b};
    else                w_sum = {r_a[DATA_W-1], r_a} + {r_b[DATA_W-1], r_b};
  end

  assign w_z = (alu_result == '0);
  assign w_n = w_arith && alu_result[DATA_W-1];
  assign w_v = w_arith && (w_sum[DATA_W] != w_sum[DATA_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_v <= 1'b0;
    end else if (r_state == EXEC) begin
      r_z <= w_z;
      r_n <= w_n;
      r_v <= w_v;
    end
  end

  assign resp_z = r_z;
  assign resp_n = r_n;
  assign resp_v = r_v;
`else
  assign resp_z = 1'b0;
  assign resp_n = 1'b0;
  assign resp_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a bench-side ALU feeds alu_result, a transaction
// level reference model predicts every output each cycle, and a set of
// directed scenarios pins literal expected values.
module tb_alu_share_arb;

`ifdef ALU_ARB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        resp_valid, resp_ready, resp_id, resp_z, resp_n, resp_v;
  logic [15:0] resp_result;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_W(16), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_z(resp_z), .resp_n(resp_n), .resp_v(resp_v)
  );

  function automatic logic [15:0] sat16(int s);
    if (s > 32767)       return 16'h7fff;
    else if (s < -32768) return 16'h8000;
    else                 return s[15:0];
  endfunction

  function automatic logic [7:0] sat8(int s);
    if (s > 127)       return 8'h7f;
    else if (s < -128) return 8'h80;
    else               return s[7:0];
  endfunction

  // Shared ALU: saturating signed ADD/SUB/PADDSB, plain logic otherwise.
  function automatic logic [15:0] alu_f(logic [15:0] a, logic [15:0] b, logic [2:0] op);
    int n;
    n = int'(b[3:0]);
    case (op)
      3'd0: return sat16(int'($signed(a)) + int'($signed(b)));
      3'd1: return sat16(int'($signed(a)) - int'($signed(b)));
      3'd2: return a ^ b;
      3'd3: return {15'd0, ^a};
      3'd4: return a << n;
      3'd5: return 16'($signed(a) >>> n);
      3'd6: return (n == 0) ? a : 16'((a >> n) | (a << (16 - n)));
      default: return {sat8(int'($signed(a[15:8])) + int'($signed(b[15:8]))),
                       sat8(int'($signed(a[7:0]))  + int'($signed(b[7:0])))};
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction at most; response visible two cycles after
  // the accept cycle, released the cycle after a resp handshake.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_acc = 0;
  bit          m_last = 1'b1;
  logic [15:0] m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0;
  bit          m_tid = 1'b0;
  logic [15:0] m_res = '0;
  bit          m_rid = 1'b0, m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

  always @(negedge clk) begin
    bit e0, e1;
    int s;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && !m_busy) begin
      if (req0_valid && req1_valid) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    chk("req0_ready",  32'(req0_ready),  32'(e0));
    chk("req1_ready",  32'(req1_ready),  32'(e1));
    chk("resp_valid",  32'(resp_valid),  32'(m_busy && cyc >= m_acc + 2));
    chk("alu_a",       32'(alu_a),       32'(m_a));
    chk("alu_b",       32'(alu_b),       32'(m_b));
    chk("alu_op",      32'(alu_op),      32'(m_op));
    chk("resp_result", 32'(resp_result), 32'(m_res));
    chk("resp_id",     32'(resp_id),     32'(m_rid));
    chk("resp_z",      32'(resp_z),      32'(m_z));
    chk("resp_n",      32'(resp_n),      32'(m_n));
    chk("resp_v",      32'(resp_v),      32'(m_v));

    if (rst) begin
      m_busy = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = '0; m_tid = 1'b0;
      m_res = '0; m_rid = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    end else if (!m_busy) begin
      if (e0 || e1) begin
        m_busy = 1'b1; m_acc = cyc; m_tid = e1; m_last = e1;
        m_a  = e1 ? req1_a  : req0_a;
        m_b  = e1 ? req1_b  : req0_b;
        m_op = e1 ? req1_op : req0_op;
      end
    end else if (cyc == m_acc + 1) begin
      m_res = alu_f(m_a, m_b, m_op);
      m_rid = m_tid;
      s = (m_op == 3'd1) ? int'($signed(m_a)) - int'($signed(m_b))
                         : int'($signed(m_a)) + int'($signed(m_b));
      m_z = FL && (m_res == 16'd0);
      m_n = FL && (m_op <= 3'd1) && m_res[15];
      m_v = FL && (m_op <= 3'd1) && (s > 32767 || s < -32768);
    end else if (cyc >= m_acc + 2 && resp_ready) begin
      m_busy = 1'b0;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  int gq[$];
  int exp_seq[4] = '{0, 1, 0, 1};
  logic [15:0] specials[6] = '{16'h0000, 16'h7fff, 16'h8000, 16'hffff, 16'h0001, 16'h1234};

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;

    // reset holds ready low even with a request pending
    tick; at_neg;
    chk("ready_in_rst", 32'(req0_ready), 32'd0);
    tick; rst = 1'b0;

    // req0 ADD 3+4
    at_neg; chk("add_ready", 32'(req0_ready), 32'd1);
    tick; req0_valid = 1'b0;
    at_neg; chk("add_exec_valid", 32'(resp_valid), 32'd0);
    tick; at_neg;
    chk("add_valid", 32'(resp_valid), 32'd1);
    chk("add_res",   32'(resp_result), 32'h0007);
    chk("add_id",    32'(resp_id), 32'd0);
    chk("add_flags", 32'({resp_z, resp_n, resp_v}), 32'd0);
    tick;

    // req1 ADD 0x7fff+1 with saturating ALU
    req1_valid = 1'b1; req1_a = 16'h7fff; req1_b = 16'h0001; req1_op = 3'd0;
    at_neg; chk("ovf_ready", 32'(req1_ready), 32'd1);
    tick; req1_valid = 1'b0;
    tick; at_neg;
    chk("ovf_res", 32'(resp_result), 32'h7fff);
    chk("ovf_id",  32'(resp_id), 32'd1);
    chk("ovf_v",   32'(resp_v), 32'(FL));
    chk("ovf_n",   32'(resp_n), 32'd0);
    tick;

    // req0 XOR to zero, response back-pressured for 5 cycles
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1234; req0_op = 3'd2;
    resp_ready = 1'b0;
    at_neg; chk("xor_ready", 32'(req0_ready), 32'd1);
    tick; req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0002; req1_op = 3'd4;
    tick;
    for (int i = 0; i < 5; i++) begin
      at_neg;
      chk("xor_hold_valid", 32'(resp_valid), 32'd1);
      chk("xor_hold_res",   32'(resp_result), 32'h0000);
      chk("xor_hold_z",     32'(resp_z), 32'(FL));
      chk("xor_hold_rdy",   32'({req0_ready, req1_ready}), 32'd0);
      tick;
    end
    resp_ready = 1'b1;
    tick; at_neg;
    chk("rr_after_req0", 32'({req0_ready, req1_ready}), 32'b01);
    tick; req0_valid = 1'b0; req1_valid = 1'b0;
    tick; tick;

    // reset in HOLD, then continuous tie: grants 0,1,0,1
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001; req1_op = 3'd0;
    resp_ready = 1'b0;
    tick; req1_valid = 1'b0;
    tick; at_neg; chk("pre_rst_hold", 32'(resp_valid), 32'd1);
    tick; rst = 1'b1; req0_valid = 1'b1;
    at_neg; chk("rst_ready", 32'(req0_ready), 32'd0);
    tick; rst = 1'b0; req1_valid = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      at_neg;
      if (i == 0) begin
        chk("post_rst_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_res",   32'(resp_result), 32'd0);
        chk("post_rst_gnt",   32'({req0_ready, req1_ready}), 32'b10);
      end
      if (req0_ready) gq.push_back(0);
      else if (req1_ready) gq.push_back(1);
      tick;
    end
    for (int i = 0; i < 4; i++)
      chk("rr_seq", (i < gq.size()) ? 32'(gq[i]) : 32'd99, 32'(exp_seq[i]));
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick;

    // SUB 0x8000-1 saturates; flags depend on build
    req0_valid = 1'b1; req0_a = 16'h8000; req0_b = 16'h0001; req0_op = 3'd1;
    tick; req0_valid = 1'b0;
    tick; at_neg;
    chk("sub_res", 32'(resp_result), 32'h8000);
    chk("sub_flags", 32'({resp_z, resp_n, resp_v}), FL ? 32'b011 : 32'b000);
    tick; tick;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      resp_ready = ($urandom_range(0, 9) < 7);
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
      req0_b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
      req1_a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
      req1_b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
      tick;
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    at_neg;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
